// File: rtl/frame_source_sched_pkg.sv
// frame_source_sched_pkg
//   Shared codes for the frame source scheduler.
//   - GEN_MODE / UART_MODE / FRAME_MODE: display mode codes, reused as
//     active-source codes (FRAME_MODE means "hold, nothing feeding").
//   - S_GEN / S_UART / S_HOLD: scheduler state encodings.
package frame_source_sched_pkg;

  localparam logic [1:0] GEN_MODE   = 2'b01;
  localparam logic [1:0] UART_MODE  = 2'b10;
  localparam logic [1:0] FRAME_MODE = 2'b11;

  localparam logic [1:0] S_GEN  = 2'd0;
  localparam logic [1:0] S_UART = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  // Source code presented on active_src for a given scheduler state.
  function automatic logic [1:0] state_to_src(input logic [1:0] st);
    case (st)
      S_GEN:   state_to_src = GEN_MODE;
      S_UART:  state_to_src = UART_MODE;
      default: state_to_src = FRAME_MODE;
    endcase
  endfunction

endpackage

// File: rtl/frame_source_sched_commit_buf.sv
// frame_source_sched_commit_buf
//   Single-entry pending frame buffer with commit on the display frame
//   boundary, so the scan datapath never sees a half-updated frame.
//   Ports:
//     clk, rst       clock, asynchronous active-high reset
//     accept         load frame_in into pending this cycle
//     frame_in       frame being accepted
//     scan_sof       frame boundary pulse from Display
//     frame_out_flat committed frame
//     frame_cnt      committed frame count (wraps)
//     drop_cnt       frames overwritten before commit (saturating)
module frame_source_sched_commit_buf
  import frame_source_sched_pkg::*;
#(
  parameter int FRAME_W = 512,
  parameter int DROP_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               accept,
  input  logic [FRAME_W-1:0] frame_in,
  input  logic               scan_sof,
  output logic [FRAME_W-1:0] frame_out_flat,
  output logic [31:0]        frame_cnt,
  output logic [DROP_W-1:0]  drop_cnt
);

  logic [FRAME_W-1:0] pending_q, pending_d;
  logic               pending_full_q, pending_full_d;
  logic [FRAME_W-1:0] frame_out_q, frame_out_d;
  logic [31:0]        frame_cnt_q, frame_cnt_d;
  logic [DROP_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic               commit;

  always_comb begin
    commit         = scan_sof && pending_full_q;
    pending_d      = pending_q;
    pending_full_d = pending_full_q;
    frame_out_d    = frame_out_q;
    frame_cnt_d    = frame_cnt_q;
    drop_cnt_d     = drop_cnt_q;

    // The old pending content is committed before the new frame lands,
    // so a simultaneous accept and scan_sof loses nothing.
    if (commit) begin
      frame_out_d    = pending_q;
      frame_cnt_d    = frame_cnt_q + 32'd1;
      pending_full_d = 1'b0;
    end

    if (accept) begin
      pending_d      = frame_in;
      pending_full_d = 1'b1;
      if (pending_full_q && !scan_sof && (drop_cnt_q != {DROP_W{1'b1}}))
        drop_cnt_d = drop_cnt_q + DROP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_full_q <= 1'b0;
      frame_out_q    <= '0;
      frame_cnt_q    <= '0;
      drop_cnt_q     <= '0;
    end else begin
      pending_full_q <= pending_full_d;
      frame_out_q    <= frame_out_d;
      frame_cnt_q    <= frame_cnt_d;
      drop_cnt_q     <= drop_cnt_d;
    end
  end

  // Pending data is only meaningful while pending_full_q is set, so it
  // carries no reset.
  always_ff @(posedge clk) begin
    pending_q <= pending_d;
  end

  assign frame_out_flat = frame_out_q;
  assign frame_cnt      = frame_cnt_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: rtl/frame_source_sched.sv
// frame_source_sched
//   Chooses which animation source (UART receiver or frame generator)
//   feeds the cube display, with automatic UART takeover and a timeout
//   fallback to the generator. Accepted frames go through a pending
//   buffer committed only at the display frame boundary.
//   Ports:
//     clk, rst         clock, asynchronous active-high reset
//     auto_en          1: automatic scheduling, 0: state follows mode_force
//     mode_force       forced mode code (manual only)
//     uart_frame_flat  / uart_valid   UART receiver frame + strobe
//     gen_frame_flat   / gen_valid    generator frame + strobe
//     scan_sof         frame boundary pulse from Display
//     uart_en, gen_en  registered source enables
//     frame_out_flat   committed frame
//     frame_cnt        committed frame count
//     drop_cnt         overwritten-before-commit count (saturating)
//     active_src       source code of the current state
module frame_source_sched
  import frame_source_sched_pkg::*;
#(
  parameter int FRAME_W        = 512,
  parameter int TIMEOUT_CYCLES = 100000000,
  parameter int DROP_W         = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               auto_en,
  input  logic [1:0]         mode_force,
  input  logic [FRAME_W-1:0] uart_frame_flat,
  input  logic               uart_valid,
  input  logic [FRAME_W-1:0] gen_frame_flat,
  input  logic               gen_valid,
  input  logic               scan_sof,
  output logic               uart_en,
  output logic               gen_en,
  output logic [FRAME_W-1:0] frame_out_flat,
  output logic [31:0]        frame_cnt,
  output logic [DROP_W-1:0]  drop_cnt,
  output logic [1:0]         active_src
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             gen_en_q, gen_en_d;
  logic             uart_en_q, uart_en_d;
  logic [1:0]       active_src_q, active_src_d;

  logic               acc_uart, acc_gen, accept;
  logic [FRAME_W-1:0] acc_frame;

  // A UART frame arriving in S_GEN under auto scheduling is the takeover
  // trigger and is itself accepted, so it wins over a same-cycle gen frame.
  always_comb begin
    acc_uart  = uart_valid && ((state_q == S_UART) ||
                               ((state_q == S_GEN) && auto_en));
    acc_gen   = gen_valid && (state_q == S_GEN) && !acc_uart;
    accept    = acc_uart || acc_gen;
    acc_frame = acc_uart ? uart_frame_flat : gen_frame_flat;
  end

  always_comb begin
    state_d = state_q;
    if (auto_en) begin
      case (state_q)
        S_GEN:   if (uart_valid) state_d = S_UART;
        S_UART:  if (!uart_valid && (to_cnt_q == TO_LAST)) state_d = S_GEN;
        default: state_d = S_GEN;
      endcase
    end else begin
      case (mode_force)
        GEN_MODE:  state_d = S_GEN;
        UART_MODE: state_d = S_UART;
        default:   state_d = S_HOLD;
      endcase
    end

    // Counter only runs while staying in S_UART without a fresh frame;
    // entry, any uart_valid, leaving and manual mode all clear it.
    to_cnt_d = '0;
    if (auto_en && (state_q == S_UART) && (state_d == S_UART) && !uart_valid)
      to_cnt_d = to_cnt_q + CNT_W'(1);

    // Enables are registered from the next state so they line up with it.
    gen_en_d     = (state_d == S_GEN);
    uart_en_d    = (state_d == S_UART) || ((state_d == S_GEN) && auto_en);
    active_src_d = state_to_src(state_d);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_GEN;
      to_cnt_q     <= '0;
      gen_en_q     <= 1'b1;
      uart_en_q    <= 1'b1;
      active_src_q <= GEN_MODE;
    end else begin
      state_q      <= state_d;
      to_cnt_q     <= to_cnt_d;
      gen_en_q     <= gen_en_d;
      uart_en_q    <= uart_en_d;
      active_src_q <= active_src_d;
    end
  end

  assign gen_en     = gen_en_q;
  assign uart_en    = uart_en_q;
  assign active_src = active_src_q;

  frame_source_sched_commit_buf #(
    .FRAME_W (FRAME_W),
    .DROP_W  (DROP_W)
  ) u_commit_buf (
    .clk            (clk),
    .rst            (rst),
    .accept         (accept),
    .frame_in       (acc_frame),
    .scan_sof       (scan_sof),
    .frame_out_flat (frame_out_flat),
    .frame_cnt      (frame_cnt),
    .drop_cnt       (drop_cnt)
  );

endmodule

// File: tb/tb_frame_source_sched.sv
module tb_frame_source_sched;
  import frame_source_sched_pkg::*;

  localparam int FW = 512;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          auto_en;
  logic [1:0]    mode_force;
  logic [FW-1:0] uart_frame_flat;
  logic          uart_valid;
  logic [FW-1:0] gen_frame_flat;
  logic          gen_valid;
  logic          scan_sof;
  logic          uart_en;
  logic          gen_en;
  logic [FW-1:0] frame_out_flat;
  logic [31:0]   frame_cnt;
  logic [DW-1:0] drop_cnt;
  logic [1:0]    active_src;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [FW-1:0] frame;
    logic [31:0]   cnt;
  } exp_t;
  exp_t exp_q[$];

  frame_source_sched #(
    .FRAME_W        (FW),
    .TIMEOUT_CYCLES (100),
    .DROP_W         (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .auto_en         (auto_en),
    .mode_force      (mode_force),
    .uart_frame_flat (uart_frame_flat),
    .uart_valid      (uart_valid),
    .gen_frame_flat  (gen_frame_flat),
    .gen_valid       (gen_valid),
    .scan_sof        (scan_sof),
    .uart_en         (uart_en),
    .gen_en          (gen_en),
    .frame_out_flat  (frame_out_flat),
    .frame_cnt       (frame_cnt),
    .drop_cnt        (drop_cnt),
    .active_src      (active_src)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic chk_frame(input string name, input logic [FW-1:0] act, input logic [FW-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h.. expected %0h..", name, act[63:0], req[63:0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic gen_pulse(input logic [FW-1:0] f);
    gen_frame_flat = f;
    gen_valid = 1'b1;
    tick();
    gen_valid = 1'b0;
  endtask

  task automatic uart_pulse(input logic [FW-1:0] f);
    uart_frame_flat = f;
    uart_valid = 1'b1;
    tick();
    uart_valid = 1'b0;
  endtask

  task automatic sof_pulse();
    scan_sof = 1'b1;
    tick();
    scan_sof = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic [FW-1:0] f, input logic [31:0] c);
    exp_t e;
    e.frame = f;
    e.cnt   = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of frame_cnt is a commit; compare against the
  // oldest expected commit.
  logic [31:0] prev_cnt = 32'd0;
  always @(negedge clk) begin
    if (rst) begin
      prev_cnt = 32'd0;
    end else if (frame_cnt !== prev_cnt) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: frame_cnt %0d with no commit expected", frame_cnt);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("commit_cnt", 64'(frame_cnt), 64'(e.cnt));
        chk_frame("commit_frame", frame_out_flat, e.frame);
      end
      prev_cnt = frame_cnt;
    end
  end

  logic [FW-1:0] fa5, f1, fg, u2, u3, u4, g1, g2, g3, h1, h2;

  initial begin
    fa5 = {64{8'hA5}};
    f1  = {64{8'h3C}};
    fg  = {64{8'h77}};
    u2  = {64{8'h11}};
    u3  = {64{8'h22}};
    u4  = {64{8'h33}};
    g1  = {64{8'h44}};
    g2  = {64{8'h55}};
    g3  = {64{8'h66}};
    h1  = {64{8'h88}};
    h2  = {64{8'h99}};

    rst = 1'b1;
    auto_en = 1'b1;
    mode_force = GEN_MODE;
    uart_frame_flat = '0;
    uart_valid = 1'b0;
    gen_frame_flat = '0;
    gen_valid = 1'b0;
    scan_sof = 1'b0;
    repeat (3) tick();
    chk_frame("rst_frame_out", frame_out_flat, '0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("rst_active_src", 64'(active_src), 64'(GEN_MODE));
    chk("rst_gen_en", 64'(gen_en), 64'd1);
    chk("rst_uart_en", 64'(uart_en), 64'd1);
    rst = 1'b0;
    tick();

    // Generator frame, committed at the next frame boundary.
    gen_pulse(fa5);
    push_exp(fa5, 32'd1);
    repeat (9) tick();
    sof_pulse();
    chk_frame("gen_commit_out", frame_out_flat, fa5);
    chk("gen_commit_cnt", 64'(frame_cnt), 64'd1);
    chk("gen_gen_en", 64'(gen_en), 64'd1);
    chk("gen_uart_en", 64'(uart_en), 64'd1);

    // UART takeover: first UART frame is kept.
    uart_pulse(f1);
    chk("takeover_src", 64'(active_src), 64'(UART_MODE));
    chk("takeover_gen_en", 64'(gen_en), 64'd0);
    chk("takeover_uart_en", 64'(uart_en), 64'd1);
    push_exp(f1, 32'd2);
    sof_pulse();
    gen_pulse(fg);          // ignored in S_UART
    sof_pulse();            // nothing pending: no commit
    chk("uart_ignore_gen_cnt", 64'(frame_cnt), 64'd2);
    chk_frame("uart_ignore_gen_out", frame_out_flat, f1);

    // Timeout: fallback 100 clocks after the last uart_valid.
    uart_pulse(u2);
    repeat (99) tick();
    chk("to100_before_gen_en", 64'(gen_en), 64'd0);
    tick();
    chk("to100_gen_en", 64'(gen_en), 64'd1);
    chk("to100_src", 64'(active_src), 64'(GEN_MODE));
    chk("to100_uart_en", 64'(uart_en), 64'd1);
    push_exp(u2, 32'd3);
    sof_pulse();

    // Extra uart_valid 99 clocks in restarts the timeout.
    uart_pulse(u3);
    chk("to199_takeover_src", 64'(active_src), 64'(UART_MODE));
    repeat (98) tick();
    uart_pulse(u4);         // overwrites u3 before commit
    repeat (99) tick();
    chk("to199_before_gen_en", 64'(gen_en), 64'd0);
    tick();
    chk("to199_gen_en", 64'(gen_en), 64'd1);
    chk("to199_drop_cnt", 64'(drop_cnt), 64'd1);
    push_exp(u4, 32'd4);
    sof_pulse();

    // Three frames without a boundary: two drops, last one wins.
    gen_pulse(g1);
    gen_pulse(g2);
    gen_pulse(g3);
    tick();
    chk("drop3_drop_cnt", 64'(drop_cnt), 64'd3);
    chk_frame("drop3_out_unchanged", frame_out_flat, u4);
    chk("drop3_cnt_unchanged", 64'(frame_cnt), 64'd4);
    push_exp(g3, 32'd5);
    sof_pulse();
    chk_frame("drop3_commit_out", frame_out_flat, g3);

    // Simultaneous scan_sof and accept.
    gen_pulse(h1);
    push_exp(h1, 32'd6);
    gen_frame_flat = h2;
    gen_valid = 1'b1;
    scan_sof = 1'b1;
    tick();
    gen_valid = 1'b0;
    scan_sof = 1'b0;
    tick();
    chk_frame("sim_out", frame_out_flat, h1);
    chk("sim_drop_cnt", 64'(drop_cnt), 64'd3);
    push_exp(h2, 32'd7);
    sof_pulse();
    chk_frame("sim_next_out", frame_out_flat, h2);

    // Manual hold: nothing accepted, nothing committed.
    auto_en = 1'b0;
    mode_force = 2'b00;
    tick();
    chk("hold_src", 64'(active_src), 64'(FRAME_MODE));
    chk("hold_gen_en", 64'(gen_en), 64'd0);
    chk("hold_uart_en", 64'(uart_en), 64'd0);
    gen_pulse(g1);
    uart_pulse(u2);
    sof_pulse();
    sof_pulse();
    chk("hold_frame_cnt", 64'(frame_cnt), 64'd7);
    chk_frame("hold_frame_out", frame_out_flat, h2);
    chk("hold_src_stays", 64'(active_src), 64'(FRAME_MODE));

    // Asynchronous reset mid-hold, checked before any clock edge.
    rst = 1'b1;
    #2;
    chk_frame("arst_frame_out", frame_out_flat, '0);
    chk("arst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("arst_drop_cnt", 64'(drop_cnt), 64'd0);
    chk("arst_active_src", 64'(active_src), 64'(GEN_MODE));
    chk("arst_gen_en", 64'(gen_en), 64'd1);
    chk("arst_uart_en", 64'(uart_en), 64'd1);
    tick();
    rst = 1'b0;
    auto_en = 1'b1;
    tick();
    sof_pulse();            // discarded pending must not commit
    chk("arst_no_commit", 64'(frame_cnt), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
